// File: rtl/time_bcd_formatter.sv
`default_nettype none
// ============================================================================
//  Module      : time_bcd_formatter
//  Description : Snapshots two time fields (HH:MM or MM:SS) on a start
//                request, applies optional 12-hour mapping and range
//                clamping, then converts both fields to BCD with a single
//                shared sequential double-dabble engine. Results, PM flag
//                and overflow flag are committed together and announced
//                with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module time_bcd_formatter #(
  parameter int         FIELD_W    = 6,
  parameter int         FD         = 2,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          state,
  input  logic [FIELD_W-1:0]  seconds,
  input  logic [FIELD_W-1:0]  minutes,
  input  logic [FIELD_W-1:0]  hours,
  input  logic                hour12,
  input  logic                blank_lz,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [8*FD-1:0]     digits,
  output logic                pm,
  output logic                ovf
);

  localparam int BCD_W   = 4 * FD;
  localparam int DD_W    = BCD_W + FIELD_W;
  localparam int CNT_W   = $clog2(FIELD_W);
  localparam int MAX_VAL = (10 ** FD) - 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONV_LO = 2'd1,
    S_CONV_HI = 2'd2,
    S_COMMIT  = 2'd3
  } fsm_t;

  fsm_t               fsm_q,      fsm_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [DD_W-1:0]    dd_q,       dd_d;
  logic [FIELD_W-1:0] hi_q,       hi_d;
  logic [BCD_W-1:0]   lo_bcd_q,   lo_bcd_d;
  logic               snap_pm_q,  snap_pm_d;
  logic               snap_ovf_q, snap_ovf_d;
  logic               blank_q,    blank_d;
  logic [8*FD-1:0]    digits_q,   digits_d;
  logic               pm_q,       pm_d;
  logic               ovf_q,      ovf_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;

  logic [FIELD_W-1:0] sel_hi, sel_lo, map_hi, clamp_hi, clamp_lo;
  logic               map_pm, clip_hi, clip_lo;
  logic [DD_W-1:0]    dd_adj, dd_step;
  logic [BCD_W-1:0]   hi_bcd, hi_disp;

  // Operand selection, 12-hour mapping and clamping of the live inputs
  always_comb begin
    sel_hi = (state == 2'd2) ? minutes : hours;
    sel_lo = (state == 2'd2) ? seconds : minutes;
    map_hi = sel_hi;
    map_pm = 1'b0;
    if (hour12 && !state[1]) begin
      if (sel_hi == '0) begin
        map_hi = FIELD_W'(12);
      end else if (sel_hi >= FIELD_W'(12)) begin
        map_pm = 1'b1;
        if (sel_hi > FIELD_W'(12)) map_hi = sel_hi - FIELD_W'(12);
      end
    end
    clip_hi  = (32'(map_hi) > 32'(MAX_VAL));
    clip_lo  = (32'(sel_lo) > 32'(MAX_VAL));
    clamp_hi = clip_hi ? FIELD_W'(MAX_VAL) : map_hi;
    clamp_lo = clip_lo ? FIELD_W'(MAX_VAL) : sel_lo;
  end

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left
  always_comb begin
    dd_adj = dd_q;
    for (int i = 0; i < FD; i++) begin
      if (dd_adj[FIELD_W+4*i +: 4] >= 4'd5)
        dd_adj[FIELD_W+4*i +: 4] = dd_adj[FIELD_W+4*i +: 4] + 4'd3;
    end
    dd_step = {dd_adj[DD_W-2:0], 1'b0};
  end

  // Hi-field display value with optional blanking of its leftmost digit
  always_comb begin
    hi_bcd  = dd_q[DD_W-1 -: BCD_W];
    hi_disp = hi_bcd;
    if (blank_q && (hi_bcd[BCD_W-1 -: 4] == 4'd0))
      hi_disp[BCD_W-1 -: 4] = BLANK_CODE;
  end

  // Next-state and datapath control for the conversion sequence
  always_comb begin
    fsm_d      = fsm_q;
    cnt_d      = cnt_q;
    dd_d       = dd_q;
    hi_d       = hi_q;
    lo_bcd_d   = lo_bcd_q;
    snap_pm_d  = snap_pm_q;
    snap_ovf_d = snap_ovf_q;
    blank_d    = blank_q;
    digits_d   = digits_q;
    pm_d       = pm_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (fsm_q)
      S_IDLE: begin
        if (start && (state != 2'd3)) begin
          fsm_d      = S_CONV_LO;
          busy_d     = 1'b1;
          cnt_d      = '0;
          dd_d       = {{BCD_W{1'b0}}, clamp_lo};
          hi_d       = clamp_hi;
          snap_pm_d  = map_pm;
          snap_ovf_d = clip_hi | clip_lo;
          blank_d    = blank_lz;
        end
      end
      S_CONV_LO: begin
        dd_d  = dd_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(FIELD_W - 1)) begin
          // Lo result parks in its own register; engine reloads with hi
          lo_bcd_d = dd_step[DD_W-1 -: BCD_W];
          dd_d     = {{BCD_W{1'b0}}, hi_q};
          cnt_d    = '0;
          fsm_d    = S_CONV_HI;
        end
      end
      S_CONV_HI: begin
        dd_d  = dd_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(FIELD_W - 1)) begin
          cnt_d = '0;
          fsm_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        digits_d = {hi_disp, lo_bcd_q};
        pm_d     = snap_pm_q;
        ovf_d    = snap_ovf_q;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        fsm_d    = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any conversion in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q      <= S_IDLE;
      cnt_q      <= '0;
      dd_q       <= '0;
      hi_q       <= '0;
      lo_bcd_q   <= '0;
      snap_pm_q  <= 1'b0;
      snap_ovf_q <= 1'b0;
      blank_q    <= 1'b0;
      digits_q   <= '0;
      pm_q       <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      cnt_q      <= cnt_d;
      dd_q       <= dd_d;
      hi_q       <= hi_d;
      lo_bcd_q   <= lo_bcd_d;
      snap_pm_q  <= snap_pm_d;
      snap_ovf_q <= snap_ovf_d;
      blank_q    <= blank_d;
      digits_q   <= digits_d;
      pm_q       <= pm_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign digits = digits_q;
  assign pm     = pm_q;
  assign ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_time_bcd_formatter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_bcd_formatter
//  Description : Self-checking bench for time_bcd_formatter. Two instances
//                (6-bit and 7-bit fields) share control inputs; results are
//                compared against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_time_bcd_formatter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  state;
  logic [6:0]  h7, m7, s7;
  logic        hour12, blank_lz, start;

  logic        busy1, done1, pm1, ovf1;
  logic [15:0] dig1;
  logic        busy2, done2, pm2, ovf2;
  logic [15:0] dig2;

  always #5 clk = ~clk;

  time_bcd_formatter #(.FIELD_W(6), .FD(2), .BLANK_CODE(4'hF)) dut1 (
    .clk(clk), .reset(reset), .state(state),
    .seconds(s7[5:0]), .minutes(m7[5:0]), .hours(h7[5:0]),
    .hour12(hour12), .blank_lz(blank_lz), .start(start),
    .busy(busy1), .done(done1), .digits(dig1), .pm(pm1), .ovf(ovf1)
  );

  time_bcd_formatter #(.FIELD_W(7), .FD(2), .BLANK_CODE(4'hF)) dut2 (
    .clk(clk), .reset(reset), .state(state),
    .seconds(s7), .minutes(m7), .hours(h7),
    .hour12(hour12), .blank_lz(blank_lz), .start(start),
    .busy(busy2), .done(done2), .digits(dig2), .pm(pm2), .ovf(ovf2)
  );

  int total = 0;
  int bad   = 0;

  // Observations recorded by launch()
  int          k1, n1, k2, n2;
  logic [15:0] g1, g2, pre1, pre2;
  logic        p1, p2, o1, o2;
  logic        b1_0, b2_0, bb1, bb2, ba1, ba2;

  // Last committed values predicted by the model
  logic [15:0] prev1 = 16'h0, prev2 = 16'h0;

  // Reference model: plain decimal arithmetic on the field values
  function automatic void model(input int mode, input int h, input int m, input int s,
                                input int h12, input int blz,
                                output logic [15:0] dg, output logic p, output logic o);
    int hi, lo;
    hi = (mode == 2) ? m : h;
    lo = (mode == 2) ? s : m;
    p  = 1'b0;
    if (mode != 2 && h12 != 0) begin
      if (hi == 0) hi = 12;
      else if (hi >= 12) begin
        p = 1'b1;
        if (hi > 12) hi = hi - 12;
      end
    end
    o = 1'b0;
    if (hi > 99) begin hi = 99; o = 1'b1; end
    if (lo > 99) begin lo = 99; o = 1'b1; end
    dg = {4'(hi / 10), 4'(hi % 10), 4'(lo / 10), 4'(lo % 10)};
    if (blz != 0 && hi < 10) dg[15:12] = 4'hF;
  endfunction

  // Pulse start, optionally disturb inputs mid-conversion, record what happens
  task automatic launch(input bit poke);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    b1_0 = busy1; b2_0 = busy2;
    k1 = -1; n1 = 0; k2 = -1; n2 = 0;
    bb1 = 1'bx; bb2 = 1'bx; ba1 = 1'bx; ba2 = 1'bx;
    for (int k = 1; k <= 35; k++) begin
      if (poke && k == 2) begin
        start = 1'b1; state = 2'($urandom);
        h7 = 7'($urandom); m7 = 7'($urandom); s7 = 7'($urandom);
        hour12 = 1'($urandom); blank_lz = 1'($urandom);
      end
      if (poke && k == 5) start = 1'b0;
      @(negedge clk);
      if (done1) begin
        if (n1 == 0) begin k1 = k; g1 = dig1; p1 = pm1; o1 = ovf1; end
        n1++;
      end
      if (done2) begin
        if (n2 == 0) begin k2 = k; g2 = dig2; p2 = pm2; o2 = ovf2; end
        n2++;
      end
      if (k == 12) begin bb1 = busy1; pre1 = dig1; end
      if (k == 13) ba1 = busy1;
      if (k == 14) begin bb2 = busy2; pre2 = dig2; end
      if (k == 15) ba2 = busy2;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; state = 2'd0;
    h7 = '0; m7 = '0; s7 = '0; hour12 = 1'b0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({dig1, busy1, done1, pm1, ovf1} !== 20'h0) begin
      bad++; $display("FAIL reset_dut1: got %h want 00000", {dig1, busy1, done1, pm1, ovf1});
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({dig2, busy2, done2, pm2, ovf2} !== 20'h0) begin
      bad++; $display("FAIL reset_dut2: got %h want 00000", {dig2, busy2, done2, pm2, ovf2});
    end
  endtask

  task automatic test_conversions;
    int tm [10] = '{0, 1, 1, 2, 2, 2, 2, 0, 0, 0};
    int th [10] = '{13, 0, 23, 0, 0, 0, 0, 12, 0, 100};
    int tmi[10] = '{7, 5, 5, 4, 4, 120, 4, 0, 0, 30};
    int ts [10] = '{0, 0, 0, 59, 59, 127, 59, 0, 0, 0};
    int t12[10] = '{0, 1, 1, 0, 0, 0, 0, 1, 0, 0};
    int tb [10] = '{0, 0, 0, 1, 0, 1, 0, 1, 1, 0};
    logic [15:0] e1, e2;
    logic ep1, ep2, eo1, eo2;
    for (int i = 0; i < 35; i++) begin
      if (i < 10) begin
        state = 2'(tm[i]); h7 = 7'(th[i]); m7 = 7'(tmi[i]); s7 = 7'(ts[i]);
        hour12 = 1'(t12[i]); blank_lz = 1'(tb[i]);
      end else begin
        state = 2'($urandom_range(0, 2));
        hour12 = 1'($urandom);
        h7 = hour12 ? 7'($urandom_range(0, 23)) : 7'($urandom_range(0, 127));
        m7 = 7'($urandom_range(0, 127)); s7 = 7'($urandom_range(0, 127));
        blank_lz = 1'($urandom);
      end
      model(int'(state), int'(h7[5:0]), int'(m7[5:0]), int'(s7[5:0]),
            int'(hour12), int'(blank_lz), e1, ep1, eo1);
      model(int'(state), int'(h7), int'(m7), int'(s7),
            int'(hour12), int'(blank_lz), e2, ep2, eo2);
      launch(1'b1);
      total++; if (k1 !== 13) begin bad++; $display("FAIL lat1 case %0d: got %0d want 13", i, k1); end
      total++; if (n1 !== 1) begin bad++; $display("FAIL ndone1 case %0d: got %0d want 1", i, n1); end
      total++; if (g1 !== e1) begin bad++; $display("FAIL digits1 case %0d: got %h want %h", i, g1, e1); end
      total++; if ({p1, o1} !== {ep1, eo1}) begin bad++; $display("FAIL pm_ovf1 case %0d: got %b%b want %b%b", i, p1, o1, ep1, eo1); end
      total++; if ({b1_0, bb1, ba1} !== 3'b110) begin bad++; $display("FAIL busy1 case %0d: got %b want 110", i, {b1_0, bb1, ba1}); end
      total++; if (pre1 !== prev1) begin bad++; $display("FAIL hold1 case %0d: got %h want %h", i, pre1, prev1); end
      total++; if (k2 !== 15) begin bad++; $display("FAIL lat2 case %0d: got %0d want 15", i, k2); end
      total++; if (n2 !== 1) begin bad++; $display("FAIL ndone2 case %0d: got %0d want 1", i, n2); end
      total++; if (g2 !== e2) begin bad++; $display("FAIL digits2 case %0d: got %h want %h", i, g2, e2); end
      total++; if ({p2, o2} !== {ep2, eo2}) begin bad++; $display("FAIL pm_ovf2 case %0d: got %b%b want %b%b", i, p2, o2, ep2, eo2); end
      total++; if ({b2_0, bb2, ba2} !== 3'b110) begin bad++; $display("FAIL busy2 case %0d: got %b want 110", i, {b2_0, bb2, ba2}); end
      total++; if (pre2 !== prev2) begin bad++; $display("FAIL hold2 case %0d: got %h want %h", i, pre2, prev2); end
      prev1 = e1; prev2 = e2;
    end
  endtask

  task automatic test_reset_mid;
    int nd;
    logic [15:0] e1;
    logic ep1, eo1;
    state = 2'd0; h7 = 7'd13; m7 = 7'd7; s7 = 7'd0; hour12 = 1'b0; blank_lz = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({dig1, busy1, done1, pm1, ovf1, dig2, busy2, done2, pm2, ovf2} !== 40'h0) begin
      bad++; $display("FAIL reset_mid: got %h/%h want 0000/0000", dig1, dig2);
    end
    @(negedge clk); reset = 1'b0;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done1 || done2 || busy1 || busy2) nd++;
    end
    total++;
    if (nd !== 0) begin bad++; $display("FAIL reset_mid_quiet: got %0d active cycles want 0", nd); end
    prev1 = 16'h0; prev2 = 16'h0;
    model(0, 13, 7, 0, 0, 0, e1, ep1, eo1);
    launch(1'b0);
    total++;
    if (k1 !== 13 || g1 !== e1) begin
      bad++; $display("FAIL after_reset: got lat %0d dig %h want lat 13 dig %h", k1, g1, e1);
    end
    prev1 = e1; prev2 = e1;
  endtask

  task automatic test_freeze;
    int nact;
    state = 2'd3; h7 = 7'($urandom); m7 = 7'($urandom); s7 = 7'($urandom);
    @(negedge clk); start = 1'b1;
    nact = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy1 || done1 || busy2 || done2) nact++;
    end
    start = 1'b0;
    total++;
    if (nact !== 0) begin bad++; $display("FAIL freeze_active: got %0d want 0", nact); end
    total++;
    if (dig1 !== prev1 || dig2 !== prev2) begin
      bad++; $display("FAIL freeze_hold: got %h/%h want %h/%h", dig1, dig2, prev1, prev2);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] ea1, ea2, eb1, gb1;
    logic dp, dov;
    int kf, nf, nf2, kb;
    state = 2'd2; h7 = 7'd0; m7 = 7'd42; s7 = 7'd17; hour12 = 1'b0; blank_lz = 1'b0;
    model(2, 0, 42, 17, 0, 0, ea1, dp, dov);
    ea2 = ea1;
    model(0, 9, 3, 0, 0, 1, eb1, dp, dov);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    kf = -1; nf = 0; nf2 = 0; kb = -1; gb1 = 'x;
    for (int k = 1; k <= 40; k++) begin
      if (k == 14) begin
        start = 1'b1; state = 2'd0; h7 = 7'd9; m7 = 7'd3; blank_lz = 1'b1;
      end
      if (k == 15) start = 1'b0;
      @(negedge clk);
      if (done1) begin
        if (nf == 0) kf = k;
        else begin kb = k; gb1 = dig1; end
        nf++;
      end
      if (done2) nf2++;
    end
    total++;
    if (kf !== 13 || kb !== 27 || nf !== 2) begin
      bad++; $display("FAIL b2b_timing: got %0d,%0d n=%0d want 13,27 n=2", kf, kb, nf);
    end
    total++;
    if (gb1 !== eb1) begin bad++; $display("FAIL b2b_digits1: got %h want %h", gb1, eb1); end
    total++;
    if (nf2 !== 1 || dig2 !== ea2) begin
      bad++; $display("FAIL b2b_dut2: got n=%0d dig %h want n=1 dig %h", nf2, dig2, ea2);
    end
    prev1 = eb1; prev2 = ea2;
  endtask

  initial begin
    test_reset;
    test_conversions;
    test_reset_mid;
    test_freeze;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
